// File: rtl/morse_display_sequencer.sv
// Holds up to 8 Morse character codes and scans them as glyph-ROM addresses, one slot per clock.
// Latency: a v_sync fall starts a scan after one LOAD cycle, and the scan then runs for 8 cycles.
// Backpressure: char_ready is low from the v_sync fall until the scan ends, and whenever clear is high.
module morse_display_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        char_valid,
    input  logic [5:0]  char_code,
    output logic        char_ready,
    input  logic        clear,
    input  logic        v_sync,
    output logic [2:0]  display_position,
    output logic [10:0] addr_fixed1,
    output logic        scan_active,
    output logic [3:0]  count,
    output logic        full
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]  pos;
        logic [10:0] addr;
        logic        act;
    } scan_t;

    state_t          state;
    state_t          state_nxt;
    scan_t           scan_q;
    scan_t           scan_d;
    logic [7:0][5:0] slot;
    logic [3:0]      cnt;
    logic            v_sync_q;
    logic            vs_fall;
    logic            rdy_q;
    logic            wr;
    logic [2:0]      pos_inc;

    assign vs_fall    = v_sync_q & ~v_sync;
    assign char_ready = rdy_q & ~clear;
    assign wr         = char_valid & char_ready;
    assign pos_inc    = scan_q.pos + 3'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; v_sync falls outside IDLE are simply dropped
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = vs_fall ? LOAD : IDLE;
            LOAD:    state_nxt = SCAN;
            SCAN:    state_nxt = (scan_q.pos == 3'd7) ? IDLE : SCAN;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next slot index and its glyph base address (code * 32)
    always_comb begin
        scan_d = '0;
        case (state)
            LOAD: begin
                scan_d.pos  = 3'd0;
                scan_d.addr = {slot[0], 5'b0};
                scan_d.act  = 1'b1;
            end
            SCAN: begin
                if (scan_q.pos != 3'd7) begin
                    scan_d.pos  = pos_inc;
                    scan_d.addr = {slot[pos_inc], 5'b0};
                    scan_d.act  = 1'b1;
                end
            end
            default: scan_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q   <= '0;
            v_sync_q <= 1'b1;
            rdy_q    <= 1'b0;
        end else begin
            scan_q   <= scan_d;
            v_sync_q <= v_sync;
            rdy_q    <= (state_nxt == IDLE);
        end
    end

    // Character store; a write into a full buffer scrolls everything down one slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
            cnt  <= 4'd0;
        end else if (clear) begin
            slot <= '0;
            cnt  <= 4'd0;
        end else if (wr) begin
            if (cnt == 4'd8) begin
                slot <= {char_code, slot[7:1]};
            end else begin
                slot[cnt[2:0]] <= char_code;
                cnt            <= cnt + 4'd1;
            end
        end
    end

    assign display_position = scan_q.pos;
    assign addr_fixed1      = scan_q.addr;
    assign scan_active      = scan_q.act;
    assign count            = cnt;
    assign full             = (cnt == 4'd8);

endmodule

// File: tb/tb_morse_display_sequencer.sv
// Directed bench for morse_display_sequencer: writes, scans, scroll, clear and reset mid-scan.
module tb_morse_display_sequencer;

    logic        clk;
    logic        rst_n;
    logic        char_valid;
    logic [5:0]  char_code;
    logic        char_ready;
    logic        clear;
    logic        v_sync;
    logic [2:0]  display_position;
    logic [10:0] addr_fixed1;
    logic        scan_active;
    logic [3:0]  count;
    logic        full;

    int checks = 0;
    int errors = 0;

    logic [7:0][10:0] e;

    morse_display_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .char_valid       (char_valid),
        .char_code        (char_code),
        .char_ready       (char_ready),
        .clear            (clear),
        .v_sync           (v_sync),
        .display_position (display_position),
        .addr_fixed1      (addr_fixed1),
        .scan_active      (scan_active),
        .count            (count),
        .full             (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_char(input logic [5:0] c);
        char_valid = 1'b1;
        char_code  = c;
        step();
        char_valid = 1'b0;
    endtask

    // Falls v_sync, checks the LOAD cycle, eight SCAN cycles and the return to IDLE.
    // vs_at / clr_at pulse v_sync low / clear high during the cycle presenting that slot.
    task automatic run_scan(input logic [7:0][10:0] ex, input int vs_at, input int clr_at,
                            input string tag);
        v_sync = 1'b0;
        step();
        v_sync = 1'b1;
        chk({tag, "_load_rdy"}, char_ready, 0);
        chk({tag, "_load_act"}, scan_active, 0);
        chk({tag, "_load_addr"}, addr_fixed1, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            v_sync = 1'b1;
            clear  = 1'b0;
            chk($sformatf("%s_pos%0d", tag, i), display_position, i);
            chk($sformatf("%s_addr%0d", tag, i), addr_fixed1, ex[i]);
            chk($sformatf("%s_act%0d", tag, i), scan_active, 1);
            chk($sformatf("%s_rdy%0d", tag, i), char_ready, 0);
            if (i == vs_at)  v_sync = 1'b0;
            if (i == clr_at) clear  = 1'b1;
        end
        step();
        v_sync = 1'b1;
        clear  = 1'b0;
        chk({tag, "_end_act"}, scan_active, 0);
        chk({tag, "_end_pos"}, display_position, 0);
        chk({tag, "_end_addr"}, addr_fixed1, 0);
        chk({tag, "_end_rdy"}, char_ready, 1);
    endtask

    initial begin
        rst_n      = 1'b1;
        char_valid = 1'b0;
        char_code  = 6'd0;
        clear      = 1'b0;
        v_sync     = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rdy", char_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_act", scan_active, 0);
        chk("rst_pos", display_position, 0);
        chk("rst_addr", addr_fixed1, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_rdy", char_ready, 1);

        // Basic scan of three codes
        write_char(6'd3);
        write_char(6'd5);
        write_char(6'd9);
        chk("cnt3", count, 3);
        e = '0;
        e[0] = 11'd96;
        e[1] = 11'd160;
        e[2] = 11'd288;
        run_scan(e, -1, -1, "scan1");

        // Clear with a character offered in IDLE: no write
        char_valid = 1'b1;
        char_code  = 6'd7;
        clear      = 1'b1;
        #1;
        chk("clr_rdy_comb", char_ready, 0);
        step();
        clear      = 1'b0;
        char_valid = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_full", full, 0);

        // Nine writes: ninth scrolls
        for (int c = 1; c <= 8; c++) write_char(6'(c));
        chk("fill_count", count, 8);
        chk("fill_full", full, 1);
        write_char(6'd9);
        chk("scroll_count", count, 8);
        chk("scroll_full", full, 1);
        for (int i = 0; i < 8; i++) e[i] = 11'((i + 2) * 32);
        run_scan(e, -1, -1, "scroll");

        // Write coinciding with the v_sync fall, plus a second fall mid-scan
        clear = 1'b1;
        step();
        clear = 1'b0;
        write_char(6'd4);
        char_valid = 1'b1;
        char_code  = 6'd10;
        v_sync     = 1'b0;
        step();
        char_valid = 1'b0;
        v_sync     = 1'b1;
        chk("coinc_count", count, 2);
        chk("coinc_rdy", char_ready, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 2) v_sync = 1'b0;
            else        v_sync = 1'b1;
            chk($sformatf("coinc_pos%0d", i), display_position, i);
            chk($sformatf("coinc_addr%0d", i), addr_fixed1,
                (i == 0) ? 128 : ((i == 1) ? 320 : 0));
        end
        step();
        v_sync = 1'b1;
        chk("coinc_end_act", scan_active, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("no_rescan_act%0d", i), scan_active, 0);
            chk($sformatf("no_rescan_rdy%0d", i), char_ready, 1);
        end

        // Clear on the edge that presents slot 3: later slots read blank
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int c = 11; c <= 18; c++) write_char(6'(c));
        e = '0;
        e[0] = 11'd352;
        e[1] = 11'd384;
        e[2] = 11'd416;
        e[3] = 11'd448;
        run_scan(e, -1, 2, "midclr");
        chk("midclr_count", count, 0);

        // Reset asserted while slot 4 is presented
        for (int c = 20; c <= 25; c++) write_char(6'(c));
        v_sync = 1'b0;
        step();
        v_sync = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("pre_rst_pos", display_position, 4);
        chk("pre_rst_addr", addr_fixed1, 768);
        rst_n = 1'b0;
        #1;
        chk("midrst_pos", display_position, 0);
        chk("midrst_addr", addr_fixed1, 0);
        chk("midrst_act", scan_active, 0);
        chk("midrst_count", count, 0);
        chk("midrst_full", full, 0);
        chk("midrst_rdy", char_ready, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rerst_rdy", char_ready, 1);
        e = '0;
        run_scan(e, -1, -1, "zero");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
